// File: rtl/mure_pkg.sv
// mure_pkg: shared types for the trace front end.
//   fu_op : functional-unit operation reported by each commit channel.
//           Only the values the itype classifier cares about are
//           distinguished. Every other operation maps onto ADD/LOAD/STORE/CSR.
package mure_pkg;
  typedef enum logic [3:0] {
    ADD, LOAD, STORE, BRANCH, JAL, JALR, MRET, SRET, DRET, CSR
  } fu_op;
endpackage

// File: rtl/itype_detector_multi_if.sv
// itype_detector_multi_if: commit-side inputs and trace-side head-row outputs
// of the itype detector.
//   slave  : detector view (commit inputs and ready_i in; head row, empty, overflow out)
//   master : driver view (the reverse directions)
interface itype_detector_multi_if #(
  parameter int NRET    = 2,
  parameter int ITYPE_W = 3
);
  logic [NRET-1:0]                valid_i;
  mure_pkg::fu_op [NRET-1:0]      op_i;
  logic [NRET-1:0]                branch_taken_i;
  logic [NRET-1:0]                exception_i;
  logic                           interrupt_i;
  logic [NRET-1:0][4:0]           rd_i;
  logic [NRET-1:0][4:0]           rs1_i;
  logic [NRET-1:0]                valid_o;
  logic [NRET-1:0][ITYPE_W-1:0]   itype_o;
  logic                           ready_i;
  logic                           empty_o;
  logic                           overflow_o;

  modport slave (
    input  valid_i, op_i, branch_taken_i, exception_i, interrupt_i, rd_i, rs1_i, ready_i,
    output valid_o, itype_o, empty_o, overflow_o
  );
  modport master (
    output valid_i, op_i, branch_taken_i, exception_i, interrupt_i, rd_i, rs1_i, ready_i,
    input  valid_o, itype_o, empty_o, overflow_o
  );
endinterface

// File: rtl/itype_detector_multi.sv
// itype_detector_multi: classifies up to NRET retiring instructions per cycle
// into E-Trace itype codes and queues each commit row in a DEPTH-row FIFO.
// Ports:
//   clk_i : clock
//   rst_i : synchronous, active-high reset
//   bus   : itype_detector_multi_if.slave (commit inputs, head-row outputs,
//           ready_i backpressure, empty_o, sticky overflow_o)
// Optional feature: define TE_ITYPE_CALLRET_EN for the 4-bit call/return
// decode of JAL/JALR. It only has an effect when ITYPE_W == 4.

// Per-channel code. Kill and interrupt targeting are resolved by the parent.
module itype_detector_lane
  import mure_pkg::*;
#(
  parameter int ITYPE_W = 3
) (
  input  logic               vld_i,   // channel present in the row (after kill)
  input  logic               exc_i,
  input  logic               irq_i,   // this channel is the interrupt target
  input  fu_op               op_i,
  input  logic               taken_i,
  input  logic [4:0]         rd_i,
  input  logic [4:0]         rs1_i,
  output logic [ITYPE_W-1:0] itype_o
);
  logic [3:0] code;

`ifdef TE_ITYPE_CALLRET_EN
  logic rd_link, rs1_link;
  assign rd_link  = (rd_i == 5'd1) || (rd_i == 5'd5);
  assign rs1_link = (rs1_i == 5'd1) || (rs1_i == 5'd5);
`else
  logic unused_regs;
  assign unused_regs = ^{rd_i, rs1_i};
`endif

  always_comb begin
    code = 4'd0;
    if (!vld_i)                                          code = 4'd0;
    else if (exc_i)                                      code = 4'd1;
    else if (irq_i)                                      code = 4'd2;
    else if (op_i == MRET || op_i == SRET || op_i == DRET) code = 4'd3;
    else if (ITYPE_W >= 3) begin
      if (op_i == BRANCH)    code = taken_i ? 4'd5 : 4'd4;
      else if (op_i == JALR) code = 4'd6;
`ifdef TE_ITYPE_CALLRET_EN
      if (ITYPE_W == 4) begin
        if (op_i == JAL) begin
          if (rd_link)              code = 4'd9;
          else if (rd_i == 5'd0)    code = 4'd11;
          else                      code = 4'd15;
        end else if (op_i == JALR) begin
          if (rd_link && rs1_link && rd_i != rs1_i) code = 4'd12;
          else if (rd_link)                        code = 4'd8;
          else if (rd_i == 5'd0 && rs1_link)       code = 4'd13;
          else if (rd_i == 5'd0)                   code = 4'd10;
          else                                     code = 4'd14;
        end
      end
`endif
    end
  end

  assign itype_o = ITYPE_W'(code);
endmodule

module itype_detector_multi
  import mure_pkg::*;
#(
  parameter int NRET    = 2,
  parameter int ITYPE_W = 3,
  parameter int DEPTH   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  itype_detector_multi_if.slave        bus
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [NRET-1:0]              vld;
    logic [NRET-1:0][ITYPE_W-1:0] ity;
  } row_t;

  logic [NRET-1:0]              killed, live, lane_vld, lane_irq;
  logic [NRET-1:0][ITYPE_W-1:0] lane_ity;
  logic                         any_live;
  row_t                         row_in;

  // Kill everything above the oldest exception. The interrupt lands on the
  // youngest surviving channel, or on a forced-valid channel 0 if none survive.
  always_comb begin
    killed   = '0;
    live     = '0;
    lane_irq = '0;
    for (int k = 1; k < NRET; k++) killed[k] = killed[k-1] | bus.exception_i[k-1];
    for (int k = 0; k < NRET; k++)
      live[k] = (bus.valid_i[k] | bus.exception_i[k]) & ~killed[k];
    any_live = |live;
    lane_vld = live;
    if (!any_live) lane_vld[0] = bus.interrupt_i;
    if (bus.interrupt_i) begin
      if (!any_live) lane_irq[0] = 1'b1;
      else
        for (int k = 0; k < NRET; k++)
          if (live[k]) begin
            lane_irq    = '0;
            lane_irq[k] = 1'b1;
          end
    end
  end

  for (genvar g = 0; g < NRET; g++) begin : g_lane
    itype_detector_lane #(.ITYPE_W(ITYPE_W)) u_lane (
      .vld_i   (lane_vld[g]),
      .exc_i   (bus.exception_i[g]),
      .irq_i   (lane_irq[g]),
      .op_i    (bus.op_i[g]),
      .taken_i (bus.branch_taken_i[g]),
      .rd_i    (bus.rd_i[g]),
      .rs1_i   (bus.rs1_i[g]),
      .itype_o (lane_ity[g])
    );
  end

  assign row_in.vld = lane_vld;
  assign row_in.ity = lane_ity;

  // FIFO
  row_t          mem_q [DEPTH];
  row_t          mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, empty, full, do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign push    = bus.interrupt_i | any_live;
  assign pop     = (|bus.valid_o) & bus.ready_i;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q | (push & full & ~pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = row_in;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Row storage needs no reset: outputs are gated by the count.
  always_ff @(posedge clk_i) begin
    if (!rst_i) mem_q <= mem_d;
  end

  assign bus.valid_o    = empty ? '0 : mem_q[rd_ptr_q].vld;
  assign bus.itype_o    = empty ? '0 : mem_q[rd_ptr_q].ity;
  assign bus.empty_o    = empty;
  assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_itype_detector_multi.sv
module tb_itype_detector_multi;
  import mure_pkg::*;

  localparam int NRET  = 2;
  localparam int DEPTH = 4;
`ifdef TE_ITYPE_CALLRET_EN
  localparam bit CR = 1'b1;
`else
  localparam bit CR = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  itype_detector_multi_if #(.NRET(NRET), .ITYPE_W(3)) i3 ();
  itype_detector_multi_if #(.NRET(NRET), .ITYPE_W(4)) i4 ();

  itype_detector_multi #(.NRET(NRET), .ITYPE_W(3), .DEPTH(DEPTH)) dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .bus(i3.slave));
  itype_detector_multi #(.NRET(NRET), .ITYPE_W(4), .DEPTH(DEPTH)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .bus(i4.slave));

  typedef struct {
    logic [1:0]      v;
    fu_op [1:0]      op;
    logic [1:0]      tk;
    logic [1:0]      ex;
    logic            irq;
    logic [1:0][4:0] rd;
    logic [1:0][4:0] rs1;
  } in_t;

  typedef struct {
    logic [1:0]      v;
    logic [1:0][3:0] c;
  } row_t;

  typedef struct {
    in_t        in;
    logic [1:0] ev;
    logic [2:0] e1, e0;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];
  row_t q3[$], q4[$];
  bit   ovf_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic in_t mk(input logic [1:0] v, input fu_op o1, input fu_op o0,
                             input logic [1:0] tk, input logic [1:0] ex, input logic irq);
    in_t x;
    x.v = v; x.op[1] = o1; x.op[0] = o0; x.tk = tk; x.ex = ex; x.irq = irq;
    x.rd = '0; x.rs1 = '0;
    return x;
  endfunction

  task automatic add(input in_t x, input logic [1:0] ev, input logic [2:0] e1, input logic [2:0] e0);
    vec_t t;
    t.in = x; t.ev = ev; t.e1 = e1; t.e0 = e0;
    tbl.push_back(t);
  endtask

  task automatic drive(input in_t x, input logic rdy);
    i3.valid_i = x.v; i3.op_i = x.op; i3.branch_taken_i = x.tk; i3.exception_i = x.ex;
    i3.interrupt_i = x.irq; i3.rd_i = x.rd; i3.rs1_i = x.rs1; i3.ready_i = rdy;
    i4.valid_i = x.v; i4.op_i = x.op; i4.branch_taken_i = x.tk; i4.exception_i = x.ex;
    i4.interrupt_i = x.irq; i4.rd_i = x.rd; i4.rs1_i = x.rs1; i4.ready_i = rdy;
  endtask

  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  function automatic bit is_link(input logic [4:0] r);
    return r == 5'd1 || r == 5'd5;
  endfunction

  // Code for an ordinary retired instruction (no exception, not the irq target).
  function automatic logic [3:0] base_code(input fu_op op, input logic tk,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input int w);
    if (op == MRET || op == SRET || op == DRET) return 4'd3;
    if (w < 3) return 4'd0;
    if (op == BRANCH) return tk ? 4'd5 : 4'd4;
    if (CR && w == 4) begin
      if (op == JAL) return is_link(rd) ? 4'd9 : (rd == 0) ? 4'd11 : 4'd15;
      if (op == JALR) begin
        if (is_link(rd) && is_link(rs1) && rd != rs1) return 4'd12;
        if (is_link(rd))                              return 4'd8;
        if (rd == 0 && is_link(rs1))                  return 4'd13;
        if (rd == 0)                                  return 4'd10;
        return 4'd14;
      end
    end
    if (op == JALR) return 4'd6;
    return 4'd0;
  endfunction

  function automatic row_t ref_row(input in_t x, input int w);
    row_t r;
    int   e   = NRET;
    int   tgt = -1;
    bit   forced;
    bit   live [NRET];
    for (int k = NRET - 1; k >= 0; k--) if (x.ex[k]) e = k;
    for (int k = 0; k < NRET; k++) begin
      live[k] = (x.v[k] || x.ex[k]) && k <= e;
      if (live[k]) tgt = k;
    end
    forced = (tgt < 0) && x.irq;
    if (forced) tgt = 0;
    for (int k = 0; k < NRET; k++) begin
      r.v[k] = live[k] || (forced && k == 0);
      if (!r.v[k])                 r.c[k] = 4'd0;
      else if (x.ex[k])            r.c[k] = 4'd1;
      else if (x.irq && k == tgt)  r.c[k] = 4'd2;
      else r.c[k] = base_code(x.op[k], x.tk[k], x.rd[k], x.rs1[k], w);
    end
    return r;
  endfunction

  function automatic logic [4:0] rnd_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd5;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic cmp_model();
    row_t h3, h4;
    h3.v = '0; h3.c = '0; h4.v = '0; h4.c = '0;
    if (q3.size() != 0) begin h3 = q3[0]; h4 = q4[0]; end
    chk("rnd3.empty", 32'(i3.empty_o), 32'(q3.size() == 0));
    chk("rnd3.ovf",   32'(i3.overflow_o), 32'(ovf_m));
    chk("rnd3.valid", 32'(i3.valid_o), 32'(h3.v));
    chk("rnd3.itype", 32'({i3.itype_o[1], i3.itype_o[0]}), 32'({h3.c[1][2:0], h3.c[0][2:0]}));
    chk("rnd4.empty", 32'(i4.empty_o), 32'(q4.size() == 0));
    chk("rnd4.ovf",   32'(i4.overflow_o), 32'(ovf_m));
    chk("rnd4.valid", 32'(i4.valid_o), 32'(h4.v));
    chk("rnd4.itype", 32'({i4.itype_o[1], i4.itype_o[0]}), 32'({h4.c[1], h4.c[0]}));
  endtask

  initial begin
    in_t idle, x;
    logic [2:0] seq [4];
    logic [3:0] cr1, cr0;

    idle = mk(2'b00, ADD, ADD, 2'b00, 2'b00, 1'b0);
    drive(idle, 1'b1);
    rst_i = 1'b1;
    cyc(); cyc();
    rst_i = 1'b0;
    chk("reset.empty", 32'(i3.empty_o), 32'd1);
    chk("reset.valid", 32'(i3.valid_o), 32'd0);
    chk("reset.itype", 32'(i3.itype_o), 32'd0);
    chk("reset.ovf",   32'(i3.overflow_o), 32'd0);

    // Single-row vectors for the 3-bit instance (ev, itype ch1, itype ch0).
    add(mk(2'b11, JALR,  BRANCH, 2'b01, 2'b00, 1'b0), 2'b11, 3'd6, 3'd5);
    add(mk(2'b10, MRET,  ADD,    2'b00, 2'b01, 1'b0), 2'b01, 3'd0, 3'd1);
    add(mk(2'b00, ADD,   ADD,    2'b00, 2'b00, 1'b1), 2'b01, 3'd0, 3'd2);
    add(mk(2'b11, ADD,   BRANCH, 2'b00, 2'b00, 1'b0), 2'b11, 3'd0, 3'd4);
    add(mk(2'b11, DRET,  SRET,   2'b00, 2'b00, 1'b1), 2'b11, 3'd2, 3'd3);
    add(mk(2'b01, ADD,   ADD,    2'b00, 2'b00, 1'b1), 2'b01, 3'd0, 3'd2);
    add(mk(2'b10, MRET,  ADD,    2'b00, 2'b00, 1'b0), 2'b10, 3'd3, 3'd0);
    add(mk(2'b00, ADD,   ADD,    2'b00, 2'b10, 1'b0), 2'b10, 3'd1, 3'd0);
    add(mk(2'b11, JALR,  ADD,    2'b00, 2'b01, 1'b1), 2'b01, 3'd0, 3'd1);
    add(mk(2'b11, BRANCH, JAL,   2'b10, 2'b00, 1'b0), 2'b11, 3'd5, 3'd0);
    foreach (tbl[i]) begin
      drive(tbl[i].in, 1'b1);
      cyc();
      chk($sformatf("vec%0d.valid", i), 32'(i3.valid_o), 32'(tbl[i].ev));
      chk($sformatf("vec%0d.ity0", i),  32'(i3.itype_o[0]), 32'(tbl[i].e0));
      chk($sformatf("vec%0d.ity1", i),  32'(i3.itype_o[1]), 32'(tbl[i].e1));
      chk($sformatf("vec%0d.nempty", i), 32'(i3.empty_o), 32'd0);
      drive(idle, 1'b1);
      cyc();
      chk($sformatf("vec%0d.drained", i), 32'(i3.empty_o), 32'd1);
    end

    // Overflow: five pushes against a stalled 4-row FIFO; the fifth is lost.
    seq[0] = 3'd4; seq[1] = 3'd5; seq[2] = 3'd3; seq[3] = 3'd6;
    drive(mk(2'b01, ADD, BRANCH, 2'b00, 2'b00, 1'b0), 1'b0); cyc();
    drive(mk(2'b01, ADD, BRANCH, 2'b01, 2'b00, 1'b0), 1'b0); cyc();
    drive(mk(2'b01, ADD, MRET,   2'b00, 2'b00, 1'b0), 1'b0); cyc();
    drive(mk(2'b01, ADD, JALR,   2'b00, 2'b00, 1'b0), 1'b0); cyc();
    chk("ovf.not_yet", 32'(i3.overflow_o), 32'd0);
    drive(mk(2'b00, ADD, ADD,    2'b00, 2'b00, 1'b1), 1'b0); cyc();
    chk("ovf.set", 32'(i3.overflow_o), 32'd1);
    drive(idle, 1'b0); cyc();
    chk("ovf.hold", 32'(i3.itype_o[0]), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf.drain%0d", i), 32'(i3.itype_o[0]), 32'(seq[i]));
      chk($sformatf("ovf.dvalid%0d", i), 32'(i3.valid_o), 32'd1);
      drive(idle, 1'b1); cyc();
    end
    chk("ovf.empty", 32'(i3.empty_o), 32'd1);
    chk("ovf.sticky", 32'(i3.overflow_o), 32'd1);
    // A push offered during reset is discarded.
    drive(mk(2'b11, ADD, ADD, 2'b00, 2'b00, 1'b0), 1'b1);
    rst_i = 1'b1; cyc(); rst_i = 1'b0;
    drive(idle, 1'b1);
    chk("rst.ovf", 32'(i3.overflow_o), 32'd0);
    chk("rst.empty", 32'(i3.empty_o), 32'd1);
    chk("rst.valid", 32'(i3.valid_o), 32'd0);
    chk("rst.itype", 32'(i3.itype_o), 32'd0);

    // Full FIFO with simultaneous push and pop: nothing is dropped.
    drive(mk(2'b01, ADD, BRANCH, 2'b00, 2'b00, 1'b0), 1'b0); cyc();
    drive(mk(2'b01, ADD, BRANCH, 2'b01, 2'b00, 1'b0), 1'b0); cyc();
    drive(mk(2'b01, ADD, MRET,   2'b00, 2'b00, 1'b0), 1'b0); cyc();
    drive(mk(2'b01, ADD, JALR,   2'b00, 2'b00, 1'b0), 1'b0); cyc();
    drive(mk(2'b00, ADD, ADD,    2'b00, 2'b00, 1'b1), 1'b1); cyc();
    chk("fullpp.ovf", 32'(i3.overflow_o), 32'd0);
    seq[0] = 3'd5; seq[1] = 3'd3; seq[2] = 3'd6; seq[3] = 3'd2;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fullpp.drain%0d", i), 32'(i3.itype_o[0]), 32'(seq[i]));
      drive(idle, 1'b1); cyc();
    end
    chk("fullpp.empty", 32'(i3.empty_o), 32'd1);

    // Call/return decode on the 4-bit instance.
    x = mk(2'b11, JAL, JALR, 2'b00, 2'b00, 1'b0);
    x.rd[0] = 5'd0; x.rs1[0] = 5'd1; x.rd[1] = 5'd1;
    cr0 = CR ? 4'd13 : 4'd6; cr1 = CR ? 4'd9 : 4'd0;
    drive(x, 1'b1); cyc();
    chk("cr.w4.jalr", 32'(i4.itype_o[0]), 32'(cr0));
    chk("cr.w4.jal",  32'(i4.itype_o[1]), 32'(cr1));
    chk("cr.w3.jalr", 32'(i3.itype_o[0]), 32'd6);
    chk("cr.w3.jal",  32'(i3.itype_o[1]), 32'd0);
    x.rd[0] = 5'd1; x.rs1[0] = 5'd1; x.rd[1] = 5'd0;
    cr0 = CR ? 4'd8 : 4'd6; cr1 = CR ? 4'd11 : 4'd0;
    drive(x, 1'b1); cyc();
    chk("cr.w4.jalr2", 32'(i4.itype_o[0]), 32'(cr0));
    chk("cr.w4.jal2",  32'(i4.itype_o[1]), 32'(cr1));
    drive(idle, 1'b1); cyc();

    // Randomized run against the reference queue model.
    rst_i = 1'b1; cyc(); rst_i = 1'b0;
    q3.delete(); q4.delete(); ovf_m = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic rdy, rst, pop, push;
      cmp_model();
      for (int k = 0; k < NRET; k++) begin
        x.op[k]  = fu_op'($urandom_range(0, 9));
        x.rd[k]  = rnd_reg();
        x.rs1[k] = rnd_reg();
        x.v[k]   = 1'($urandom_range(0, 1));
        x.tk[k]  = 1'($urandom_range(0, 1));
        x.ex[k]  = ($urandom_range(0, 7) == 0);
      end
      x.irq = ($urandom_range(0, 7) == 0);
      rdy   = ($urandom_range(0, 2) != 0);
      rst   = ($urandom_range(0, 99) == 0);
      if (rst) begin
        q3.delete(); q4.delete(); ovf_m = 1'b0;
      end else begin
        pop  = (q3.size() != 0) && rdy;
        push = x.irq || (ref_row(x, 3).v != 0);
        if (push && q3.size() == DEPTH && !pop) ovf_m = 1'b1;
        if (pop) begin void'(q3.pop_front()); void'(q4.pop_front()); end
        if (push && q3.size() < DEPTH) begin
          q3.push_back(ref_row(x, 3));
          q4.push_back(ref_row(x, 4));
        end
      end
      drive(x, rdy);
      rst_i = rst;
      cyc();
      rst_i = 1'b0;
    end
    cmp_model();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
